// File: rtl/clkdiv_pkg.sv
// Shared constants and duty-cycle helper for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned DIV_MIN = 2;

  // Cycles spent HIGH in a period of n input clocks (ceil(n/2)).
  function automatic int unsigned hi_cnt(input int unsigned n);
    return n - (n / 2);
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: active/pending ratio, period counter, registered clk_out and tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_val,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] n_q, n_d, p_q, p_d, cnt_q, cnt_d, n_eff;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, wrap;

  always_comb begin
    n_d    = n_q;
    p_d    = p_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    wrap   = (cnt_q == n_q - 1'b1);
    n_eff  = pend_q ? p_q : n_q;
    if (!en) begin
      // Parked one short of wrap so the first enabled edge starts a fresh period.
      n_d    = n_eff;
      cnt_d  = n_eff - 1'b1;
      pend_d = 1'b0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap && pend_q) begin
        n_d    = p_q;
        pend_d = 1'b0;
      end
      clk_d  = (cnt_d < DIV_W'(hi_cnt(32'(n_d))));
      tick_d = wrap;
    end
    // A load on the boundary edge survives the clear above and waits a full period.
    if (ld) begin
      p_d    = ld_val;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      n_q    <= DIV_W'(DEFAULT_DIV);
      p_q    <= DIV_W'(DEFAULT_DIV);
      cnt_q  <= DIV_W'(DEFAULT_DIV - 1);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign busy    = pend_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: load decode, error pulse, channel array.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_load,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_value,
  output logic              div_err,
  output logic [NUM_CH-1:0] div_busy,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic              reject, div_err_d, div_err_q;
  logic [NUM_CH-1:0] ld_vec;

  always_comb begin
    reject    = (div_value < DIV_W'(DIV_MIN)) || (int'(div_sel) >= NUM_CH);
    div_err_d = div_load && reject;
    ld_vec    = '0;
    for (int i = 0; i < NUM_CH; i++)
      ld_vec[i] = div_load && !reject && (int'(div_sel) == i);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) div_err_q <= 1'b0;
    else          div_err_q <= div_err_d;
  end

  assign div_err = div_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clkdiv_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .en      (ch_en[g]),
      .ld      (ld_vec[g]),
      .ld_val  (div_value),
      .busy    (div_busy[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed + randomized bench for prog_clock_divider against a period-position reference model.
module tb_prog_clock_divider;

  localparam int NUM_CH      = 5;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int SEL_W       = 3;

  logic              clk_in = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] ch_en;
  logic              div_load;
  logic [SEL_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_value;
  logic              div_err;
  logic [NUM_CH-1:0] div_busy, clk_out, tick;

  prog_clock_divider #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .ch_en     (ch_en),
    .div_load  (div_load),
    .div_sel   (div_sel),
    .div_value (div_value),
    .div_err   (div_err),
    .div_busy  (div_busy),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference: each channel knows its position within the current period (-1 = stopped).
  int m_n   [NUM_CH];
  int m_p   [NUM_CH];
  int m_pos [NUM_CH];
  bit m_pend[NUM_CH];
  logic [NUM_CH-1:0] e_clk, e_tick, e_busy;
  logic              e_err;

  task automatic model_edge();
    bit rej;
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_n[c] = DEFAULT_DIV; m_p[c] = DEFAULT_DIV; m_pos[c] = -1; m_pend[c] = 0;
      end
      e_clk = '0; e_tick = '0; e_err = 1'b0;
    end else begin
      rej   = (int'(div_value) < 2) || (int'(div_sel) >= NUM_CH);
      e_err = div_load && rej;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!ch_en[c]) begin
          if (m_pend[c]) m_n[c] = m_p[c];
          m_pend[c] = 0; m_pos[c] = -1; e_clk[c] = 1'b0; e_tick[c] = 1'b0;
        end else begin
          if (m_pos[c] < 0 || m_pos[c] == m_n[c] - 1) begin
            m_pos[c] = 0;
            if (m_pend[c]) begin m_n[c] = m_p[c]; m_pend[c] = 0; end
            e_tick[c] = 1'b1;
          end else begin
            m_pos[c]++;
            e_tick[c] = 1'b0;
          end
          e_clk[c] = (m_pos[c] < (m_n[c] + 1) / 2);
        end
        if (div_load && !rej && int'(div_sel) == c) begin
          m_p[c] = int'(div_value); m_pend[c] = 1;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) e_busy[c] = m_pend[c];
  endtask

  task automatic check(input string tag);
    n_compared += 4;
    assert (clk_out === e_clk) else begin
      n_mismatched++; $error("FAIL %s clk_out observed=%b expected=%b", tag, clk_out, e_clk);
    end
    assert (tick === e_tick) else begin
      n_mismatched++; $error("FAIL %s tick observed=%b expected=%b", tag, tick, e_tick);
    end
    assert (div_busy === e_busy) else begin
      n_mismatched++; $error("FAIL %s div_busy observed=%b expected=%b", tag, div_busy, e_busy);
    end
    assert (div_err === e_err) else begin
      n_mismatched++; $error("FAIL %s div_err observed=%b expected=%b", tag, div_err, e_err);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic do_load(input int sel, input int val, input string tag);
    div_load  = 1'b1;
    div_sel   = SEL_W'(sel);
    div_value = DIV_W'(val);
    step(tag);
    div_load  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ch_en = '0; div_load = 1'b0; div_sel = '0; div_value = '0;
    run("reset", 2);
    n_compared++;
    assert (clk_out === '0 && tick === '0 && div_busy === '0 && div_err === 1'b0) else begin
      n_mismatched++;
      $error("FAIL reset_const observed=%b/%b/%b/%b expected=all zero", clk_out, tick, div_busy, div_err);
    end

    reset_n = 1'b1;
    ch_en   = 5'b00001;
    run("ch0_n4", 12);

    ch_en = '1;
    run("all_on", 3);
    do_load(1, 5, "load_ch1");
    run("ch1_n5", 14);

    do_load(2, 6, "load_ch2_a");
    do_load(2, 8, "load_ch2_b");
    run("ch2_n8", 20);

    do_load(0, 1, "bad_val");
    run("after_bad_val", 2);
    do_load(NUM_CH, 5, "bad_sel");
    run("after_bad_sel", 2);
    do_load(7, 0, "bad_both");
    run("after_bad_both", 6);

    for (int k = 0; k < 8 && !e_clk[0]; k++) step("wait_hi0");
    ch_en[0] = 1'b0;
    run("ch0_stop", 4);
    ch_en[0] = 1'b1;
    run("ch0_restart", 10);

    do_load(3, 7, "load_ch3");
    run("ch3_pend", 1);
    reset_n = 1'b0;
    ch_en   = '1;
    div_load = 1'b1; div_sel = 3'd3; div_value = 8'd9;
    step("reset_mid");
    div_load = 1'b0;
    reset_n  = 1'b1;
    run("post_reset", 10);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 31) == 0) ch_en[c] = ~ch_en[c];
      div_load  = ($urandom_range(0, 3) == 0);
      div_sel   = SEL_W'($urandom_range(0, 7));
      div_value = ($urandom_range(0, 15) == 0) ? DIV_W'($urandom_range(13, 40))
                                               : DIV_W'($urandom_range(0, 12));
      step("random");
    end
    div_load = 1'b0;
    reset_n  = 1'b1;
    run("drain", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter NUM_CH, 4, number of independent divider channels (1..16).
REQ-002 Parameter DIV_W, 8, width of the divide-ratio field.
REQ-003 Parameter DEFAULT_DIV, 4, divide ratio loaded into every channel at reset (2..2^DIV_W-1).
REQ-004 clk_in  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset, sampled on clk_in rising edge.
REQ-006 ch_en  input  NUM_CH  per-channel run enable.
REQ-007 div_load  input  1  one-cycle strobe: write div_value to channel div_sel.
REQ-008 div_sel  input  clog2(NUM_CH) (min 1)  target channel for div_load.
REQ-009 div_value  input  DIV_W  requested divide ratio N.
REQ-010 div_err  output  1  registered one-cycle pulse: last div_load rejected.
REQ-011 div_busy  output  NUM_CH  channel holds a pending ratio not yet applied.
REQ-012 clk_out  output  NUM_CH  registered divided clock per channel.
REQ-013 tick  output  NUM_CH  registered one-cycle pulse coincident with each clk_out rising edge.

Function
REQ-014 Each channel SHALL hold active ratio N, pending ratio P, pending flag, counter cnt (DIV_W bits).
REQ-015 Running channel: cnt_nxt = (cnt == N-1) ? 0 : cnt+1 each edge; cnt <= cnt_nxt.
REQ-016 clk_out SHALL be registered as (cnt_nxt < N - floor(N/2)): high ceil(N/2) cycles, low floor(N/2) cycles, period exactly N clk_in cycles.
REQ-017 tick SHALL be registered as (cnt_nxt == 0) while running, else 0.
REQ-018 div_load with div_value < 2 or div_sel >= NUM_CH SHALL be rejected: no state change, div_err = 1 next cycle.
REQ-019 Accepted div_load SHALL set P = div_value and pending flag; div_busy[ch] = 1 from next cycle.
REQ-020 A second accepted load to a channel with pending set SHALL overwrite P (last write wins).
REQ-021 Running channel SHALL apply P only at period boundary: on the edge where cnt_nxt would be 0, N <= P, pending cleared, new period uses P for HIGH/LOW and wrap.
REQ-022 Load on the boundary edge itself SHALL become pending for the following boundary; no partial period permitted.
REQ-023 ch_en[ch] = 0 SHALL, next edge: cnt <= N-1 (using P if pending, applied immediately), clk_out <= 0, tick <= 0, pending cleared.
REQ-024 First enabled edge after stop or reset: cnt -> 0, clk_out -> 1, tick -> 1 (rising edge one cycle after enable sampled high).
REQ-025 Channels SHALL be fully independent; loads to one channel SHALL not disturb others.

Reset
REQ-026 reset_n = 0 on an edge: N = DEFAULT_DIV, cnt = DEFAULT_DIV-1, pending = 0, clk_out = 0, tick = 0, div_busy = 0, div_err = 0 for all channels.
REQ-027 Reset SHALL override ch_en and div_load in the same cycle; a reset mid-period SHALL discard pending ratios.

Structure
REQ-028 Package clkdiv_pkg SHALL hold DIV_MIN (=2) constant and the high-count function ceil(N/2).
REQ-029 Per-channel logic SHALL be sub-module clkdiv_chan, generated NUM_CH times; top holds load decode and div_err.

Verification
REQ-030 Reset, ch_en=1 on ch0, N=4 -> clk_out[0] 1100 repeating, tick every 4 cycles, first rise 1 cycle after enable.
REQ-031 Load N=5 on ch1 -> clk_out[1] high 3 / low 2; change takes effect only at next wrap, div_busy[1] high until then.
REQ-032 Two loads (6 then 8) to ch2 within one period -> only 8 applied at boundary, period 8, high 4.
REQ-033 div_value=1, then div_sel=NUM_CH -> div_err pulses each time, all channel periods unchanged.
REQ-034 Drop ch_en[0] mid-high-phase -> clk_out[0]=0 next cycle, held; re-enable -> rise after 1 cycle, full period.
REQ-035 Assert reset_n=0 mid-period with pending on ch3 -> all outputs 0, ratio back to DEFAULT_DIV, div_busy cleared.
